// File: rtl/fp_normalizer.sv
// Post-add FP normalizer: carry right-shift on load, then one left shift per cycle.
// Optional round-half-up on the guard bit when FP_NORM_ROUND_EN is defined.
module fp_normalizer #(
  parameter int MANT_W = 8,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [MANT_W:0]   mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero,
  output logic              ovf,
  output logic              uf
);

  localparam int CW = $clog2(MANT_W);
  localparam logic [CW-1:0] CMAX = CW'(MANT_W - 1);

`ifdef FP_NORM_ROUND_EN
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t state, nxt;

  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  ex;
  logic [CW-1:0]     cnt;
  logic              sgn, zf, of, uff;
  logic              stop;
  logic [EXP_W-1:0]  ein_inc;
  logic              ein_sat;

  assign ein_inc = exp_in + EXP_W'(1);
  // exponent saturates at all-ones; wrap to zero also counts as overflow
  assign ein_sat = (ein_inc == '1) | (ein_inc == '0);

  assign stop = mant[MANT_W-1] | ~|mant | of | ~|ex | (cnt == CMAX);

`ifdef FP_NORM_ROUND_EN
  logic             guard;
  logic [EXP_W-1:0] ex_inc;
  logic             ex_sat;

  assign ex_inc = ex + EXP_W'(1);
  assign ex_sat = (ex_inc == '1) | (ex_inc == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (in_valid) nxt = SHIFT;
`ifdef FP_NORM_ROUND_EN
      SHIFT: if (stop) nxt = ROUND;
      ROUND: nxt = DONE;
`else
      SHIFT: if (stop) nxt = DONE;
`endif
      DONE:  if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant <= '0;
      ex   <= '0;
      cnt  <= '0;
      sgn  <= 1'b0;
      zf   <= 1'b0;
      of   <= 1'b0;
      uff  <= 1'b0;
`ifdef FP_NORM_ROUND_EN
      guard <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sgn <= sign_in;
          cnt <= '0;
          zf  <= 1'b0;
          of  <= 1'b0;
          uff <= 1'b0;
`ifdef FP_NORM_ROUND_EN
          guard <= 1'b0;
`endif
          if (mant_in == '0) begin
            mant <= '0;
            ex   <= '0;
            zf   <= 1'b1;
          end else if (mant_in[MANT_W]) begin
            if (ein_sat) begin
              mant <= '0;
              ex   <= '1;
              of   <= 1'b1;
            end else begin
              mant <= mant_in[MANT_W:1];
              ex   <= ein_inc;
`ifdef FP_NORM_ROUND_EN
              guard <= mant_in[0];
`endif
            end
          end else begin
            mant <= mant_in[MANT_W-1:0];
            ex   <= exp_in;
          end
        end
        SHIFT: begin
          if (stop) begin
            uff <= ~|ex & ~mant[MANT_W-1] & |mant;
          end else begin
            mant <= {mant[MANT_W-2:0], 1'b0};
            ex   <= ex - EXP_W'(1);
            cnt  <= cnt + CW'(1);
          end
        end
`ifdef FP_NORM_ROUND_EN
        ROUND: if (guard && !of) begin
          if (&mant) begin
            if (ex_sat) begin
              mant <= '0;
              ex   <= '1;
              of   <= 1'b1;
            end else begin
              mant <= {1'b1, {(MANT_W-1){1'b0}}};
              ex   <= ex_inc;
            end
          end else begin
            mant <= mant + MANT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign sign_out = sgn;
  assign mant_out = mant;
  assign exp_out  = ex;
  assign zero     = zf;
  assign ovf      = of;
  assign uf       = uff;

endmodule

// File: doc/fp_normalizer.md
# fp_normalizer

Sequential post-add normalizer for the floating-point adder datapath. Takes the raw mantissa sum (with carry-out) and the pre-normalization exponent from the mantissa add/subtract stage, and normalizes the mantissa so its MSB is set. It shifts left one bit per cycle, adjusting the exponent, and flags zero, overflow and underflow. It is the back end of the FP add pipeline, sitting between the mantissa adder and the result packer, with valid/ready handshakes on both sides.

## Interface
- MANT_W, 8, mantissa width including hidden bit
- EXP_W, 8, biased exponent width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operand valid
- in_ready  output  1  block can accept (high only in IDLE)
- sign_in  input  1  result sign, passed through
- mant_in  input  MANT_W+1  raw sum; bit MANT_W is adder carry-out
- exp_in  input  EXP_W  pre-normalization exponent
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  downstream accepts result
- sign_out  output  1  registered sign
- mant_out  output  MANT_W  normalized mantissa
- exp_out  output  EXP_W  adjusted exponent
- zero  output  1  result is zero
- ovf  output  1  exponent overflow (result is infinity)
- uf  output  1  exponent reached 0 before normalization (denormal)

## Operation
- FSM states: IDLE, SHIFT, ROUND (only when the macro is defined), DONE.
- IDLE: in_ready=1. When in_valid&in_ready:
  - Load sign, mantissa and exponent; go to SHIFT.
  - If mant_in[MANT_W]=1: load mant_in[MANT_W:1], save mant_in[0] as the guard bit, exp=exp_in+1.
  - If the exp_in+1 result is all-ones: set ovf, force mantissa to 0.
  - If mant_in=0: exp=0, zero=1.
- SHIFT, one cycle per step:
  - Stop when mant[MANT_W-1]=1, mant=0, ovf set, or exp=0.
  - Otherwise mant<<=1 (0 shifted in), exp-=1.
  - Stopping with exp=0 and mant MSB=0 sets uf.
  - On stop, go to ROUND if configured, else DONE.
  - At most MANT_W-1 shifts, enforced by an internal shift counter.
- DONE: out_valid=1 and outputs are held stable until out_ready. On out_valid&out_ready go to IDLE.
- No bypass: in_ready rises the cycle after the DONE handshake.
- Arithmetic: all exponent math is unsigned EXP_W bits. No wrap is permitted, because ovf saturates and uf stops at 0.

## Timing
- Reset (async, rst_n low): state=IDLE. in_ready=1 once released. All other outputs are 0.
- Reset asserted mid-operation aborts the operation immediately. The partial result is discarded and no out_valid is produced.
- Latency from the accept edge to out_valid high is N+1 cycles, where N is the number of left shifts. Add 1 cycle if ROUND is present.
- A right shift for carry costs no extra cycle; it is done in the load.
- Zero and overflow inputs take N=0.
- Backpressure: out_valid stays high with outputs frozen for any number of cycles while out_ready=0.

## Configuration
- FP_NORM_ROUND_EN defined:
  - ROUND state applies round-half-up using the guard bit: mant+=guard.
  - If the increment carries out (mant becomes all-zero with carry), the mantissa becomes 1000…0 and exp+=1, with an ovf check.
  - Adds 1 cycle of latency.
- FP_NORM_ROUND_EN undefined: the guard bit is dropped (truncation). There is no ROUND state; SHIFT goes directly to DONE.

## Test plan
All scenarios use MANT_W=8, EXP_W=8.
- Already normalized: mant_in=9'h080, exp_in=8'h10 -> mant_out=8'h80, exp_out=8'h10, flags 0, out_valid 1 cycle after accept (2 with rounding).
- Max left shift: mant_in=9'h001, exp_in=8'h10 -> mant_out=8'h80, exp_out=8'h09, out_valid 8 cycles after accept.
- Carry and rounding: mant_in=9'h103, exp_in=8'h10 -> exp_out=8'h11. mant_out=8'h81 without the macro, 8'h82 with it.
  - With the macro, mant_in=9'h1FF, exp_in=8'h10 -> mant_out=8'h80, exp_out=8'h12.
- Zero and overflow:
  - mant_in=0 -> zero=1, exp_out=0.
  - mant_in=9'h100, exp_in=8'hFE -> exp_out=8'hFF, mant_out=0, ovf=1.
- Underflow: mant_in=9'h004, exp_in=8'h03 -> 3 shifts, mant_out=8'h20, exp_out=0, uf=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
  - Pulse rst_n low during SHIFT of the max-shift case -> state IDLE, out_valid never asserts, next operand processes correctly.
